seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential unsigned restoring divider. One quotient bit is
//               produced per clock in RUN; N RUN cycles per division. A zero
//               divisor short-circuits straight to DONE with a flag set.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int N = 8
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         St,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Idle,
  output logic         Busy,
  output logic         Done,
  output logic         DivZero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [N:0]      a;          // partial remainder, one guard bit
  logic [N-1:0]    q;          // dividend shifting out, quotient shifting in
  logic [N-1:0]    d;          // latched divisor
  logic [CW-1:0]   cnt;        // remaining steps minus one

  logic [N:0]      shifted;
  logic [N:0]      trial;
  logic [N:0]      a_next;
  logic [N-1:0]    q_next;

  // State register
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and status decode from state alone
  always_comb begin
    next_state = state;
    Idle       = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        Idle = 1'b1;
        if (St) begin
          next_state = (Divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (cnt == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        Done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // One restoring step: shift {A,Q} left, try subtracting D, keep if non-negative
  always_comb begin
    shifted = {a[N-1:0], q[N-1]};
    trial   = shifted - {1'b0, d};
    a_next  = shifted;
    q_next  = {q[N-2:0], 1'b0};
    if (!trial[N]) begin
      a_next = trial;
      q_next = {q[N-2:0], 1'b1};
    end
  end

  // Datapath and result registers; results only update on entry to DONE
  always_ff @(posedge Clk) begin
    if (reset) begin
      a         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (St) begin
            q   <= Dividend;
            d   <= Divisor;
            a   <= '0;
            cnt <= CW'(N - 1);
            if (Divisor == '0) begin
              // No iterations are possible; report saturated quotient
              DivZero   <= 1'b1;
              Quotient  <= '1;
              Remainder <= Dividend;
            end else begin
              DivZero   <= 1'b0;
            end
          end
        end
        RUN: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            // Final step: publish the freshly computed values
            Quotient  <= q_next;
            Remainder <= a_next[N-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
